// File: rtl/frame_trigger_pkg.sv
// Shared types for the frame trigger: FSM state encoding and frame counter width.
package frame_trigger_pkg;

  localparam int unsigned FrameCntW = 32;

  typedef enum logic [1:0] {
    StWaitLoad = 2'd0,
    StArmed    = 2'd1,
    StDumping  = 2'd2,
    StDone     = 2'd3
  } trig_state_e;

endpackage

// File: rtl/frame_trigger_len.sv
// Saturating frame-period counter; latches the period and an overflow flag on each vs fall.
module frame_trigger_len #(
  parameter int unsigned LENW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fall,
  output logic [LENW-1:0] frame_len,
  output logic            len_ovf
);

  localparam logic [LENW-1:0] LenMax = '1;

  logic [LENW-1:0] len_cnt_q;
  logic            len_sat;

  assign len_sat = (len_cnt_q == LenMax);

  // The fall cycle itself counts toward the period, hence the +1 on capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_cnt_q <= '0;
      frame_len <= '0;
      len_ovf   <= 1'b0;
    end else if (fall) begin
      len_cnt_q <= '0;
      frame_len <= len_sat ? LenMax : len_cnt_q + LENW'(1);
      len_ovf   <= len_sat;
    end else if (!len_sat) begin
      len_cnt_q <= len_cnt_q + LENW'(1);
    end
  end

endmodule

// File: rtl/frame_trigger.sv
// Frame counter and dump-window generator driven by vertical sync and the ROM-download flag.
module frame_trigger
  import frame_trigger_pkg::*;
#(
  parameter logic [FrameCntW-1:0] START_FRAME = '0,
  parameter logic [FrameCntW-1:0] STOP_FRAME  = '1,
  parameter bit                   USE_LOAD    = 1'b1,
  parameter int unsigned          LENW        = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vs,
  input  logic                 dwnld,
  output logic [FrameCntW-1:0] frame_cnt,
  output logic                 vs_fall,
  output logic                 dump_en,
  output logic                 dump_start,
  output logic                 dump_stop,
  output logic [LENW-1:0]      frame_len,
  output logic                 len_ovf
);

  localparam trig_state_e ResetState = USE_LOAD ? StWaitLoad : StArmed;

  logic        vs_q;
  logic        dwnld_q;
  logic        fall;
  logic        dl_end;
  logic        dl_rise;
  trig_state_e state_q;

  assign fall    = vs_q & ~vs;
  assign dl_end  = dwnld_q & ~dwnld;
  assign dl_rise = ~dwnld_q & dwnld;

  // vs_q resets high so a vs held low through reset is not seen as a fall on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q      <= 1'b1;
      dwnld_q   <= 1'b0;
      vs_fall   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_q    <= vs;
      dwnld_q <= dwnld;
      vs_fall <= fall;
      if (dwnld || dl_end) begin
        frame_cnt <= '0;
      end else if (fall) begin
        frame_cnt <= frame_cnt + FrameCntW'(1);
      end
    end
  end

  // Decisions use the registered frame_cnt/vs_fall, putting the window one cycle behind them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ResetState;
      dump_en    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
    end else begin
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      if (dl_rise) begin
        state_q   <= ResetState;
        dump_en   <= 1'b0;
        dump_stop <= (state_q == StDumping);
      end else begin
        case (state_q)
          StWaitLoad: begin
            if (dl_end) state_q <= StArmed;
          end
          StArmed: begin
            if (frame_cnt == START_FRAME) begin
              state_q    <= StDumping;
              dump_en    <= 1'b1;
              dump_start <= 1'b1;
            end
          end
          StDumping: begin
            if (vs_fall && (frame_cnt == STOP_FRAME)) begin
              state_q   <= StDone;
              dump_en   <= 1'b0;
              dump_stop <= 1'b1;
            end
          end
          StDone: begin
            state_q <= StDone;
          end
          default: begin
            state_q <= ResetState;
            dump_en <= 1'b0;
          end
        endcase
      end
    end
  end

  frame_trigger_len #(
    .LENW (LENW)
  ) u_len (
    .clk       (clk),
    .rst_n     (rst_n),
    .fall      (fall),
    .frame_len (frame_len),
    .len_ovf   (len_ovf)
  );

endmodule

// File: tb/tb_frame_trigger.sv
// Directed bench for frame_trigger: two instances with different parameters share clock and vs.
module tb_frame_trigger;
  import frame_trigger_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic vs;
  logic dwnld_a;
  logic dwnld_b;

  logic [31:0] frame_cnt_a, frame_cnt_b;
  logic        vs_fall_a, vs_fall_b;
  logic        dump_en_a, dump_en_b;
  logic        dump_start_a, dump_start_b;
  logic        dump_stop_a, dump_stop_b;
  logic [23:0] frame_len_a;
  logic [7:0]  frame_len_b;
  logic        len_ovf_a, len_ovf_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fall_q[$];
  int a_start_n = 0, a_stop_n = 0, a_en_n = 0;
  int a_start_cyc = -1, a_stop_cyc = -1;

  always #5 clk = ~clk;

  frame_trigger #(
    .START_FRAME (32'd2),
    .STOP_FRAME  (32'd4),
    .USE_LOAD    (1'b0),
    .LENW        (24)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs         (vs),
    .dwnld      (dwnld_a),
    .frame_cnt  (frame_cnt_a),
    .vs_fall    (vs_fall_a),
    .dump_en    (dump_en_a),
    .dump_start (dump_start_a),
    .dump_stop  (dump_stop_a),
    .frame_len  (frame_len_a),
    .len_ovf    (len_ovf_a)
  );

  frame_trigger #(
    .START_FRAME (32'd1),
    .STOP_FRAME  (32'd3),
    .USE_LOAD    (1'b1),
    .LENW        (8)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs         (vs),
    .dwnld      (dwnld_b),
    .frame_cnt  (frame_cnt_b),
    .vs_fall    (vs_fall_b),
    .dump_en    (dump_en_b),
    .dump_start (dump_start_b),
    .dump_stop  (dump_stop_b),
    .frame_len  (frame_len_b),
    .len_ovf    (len_ovf_b)
  );

  // cyc = number of rising edges so far; window events of dut_a are logged against it.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (dump_start_a) begin a_start_n++; a_start_cyc = cyc; end
    if (dump_stop_a)  begin a_stop_n++;  a_stop_cyc  = cyc; end
    if (dump_en_a)    a_en_n++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each frame starts with vs low; the fall is sampled on the next rising edge.
  task automatic frames(input int n, input int period, input int low);
    for (int f = 0; f < n; f++) begin
      vs = 1'b0;
      fall_q.push_back(cyc + 1);
      repeat (low) tick();
      vs = 1'b1;
      repeat (period - low) tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    vs      = 1'b1;
    dwnld_a = 1'b0;
    dwnld_b = 1'b0;
    tick();
    tick();
    check("rst_frame_cnt", frame_cnt_a, 32'd0);
    check("rst_vs_fall", 32'(vs_fall_a), 32'd0);
    check("rst_dump_en", 32'(dump_en_a), 32'd0);
    check("rst_frame_len", 32'(frame_len_a), 32'd0);
    check("rst_len_ovf", 32'(len_ovf_a), 32'd0);
    check("rst_state_a", 32'(dut_a.state_q), 32'(StArmed));
    check("rst_state_b", 32'(dut_b.state_q), 32'(StWaitLoad));
    rst_n = 1'b1;
    tick();

    // Basic counting: window covers frames 2 and 3.
    frames(4, 100, 10);
    check("basic_start_n", 32'(a_start_n), 32'd1);
    check("basic_start_cyc", 32'(a_start_cyc), 32'(fall_q[1] + 1));
    check("basic_stop_n", 32'(a_stop_n), 32'd1);
    check("basic_stop_cyc", 32'(a_stop_cyc), 32'(fall_q[3] + 1));
    check("basic_en_cycles", 32'(a_en_n), 32'd200);
    check("basic_state_done", 32'(dut_a.state_q), 32'(StDone));
    check("basic_frame_cnt", frame_cnt_a, 32'd4);
    check("len100_a", 32'(frame_len_a), 32'd100);
    check("len100_b", 32'(frame_len_b), 32'd100);
    check("len100_ovf_b", 32'(len_ovf_b), 32'd0);

    // Frame length at 1000 clocks: fits in 24 bits, saturates 8 bits.
    frames(2, 1000, 10);
    check("len1000_a", 32'(frame_len_a), 32'd1000);
    check("len1000_ovf_a", 32'(len_ovf_a), 32'd0);
    check("len1000_b_sat", 32'(frame_len_b), 32'd255);
    check("len1000_ovf_b", 32'(len_ovf_b), 32'd1);

    // Download gating on dut_b.
    dwnld_b = 1'b1;
    tick();
    frames(5, 20, 5);
    check("gate_cnt_held", frame_cnt_b, 32'd0);
    check("gate_state_wait", 32'(dut_b.state_q), 32'(StWaitLoad));
    dwnld_b = 1'b0;
    tick();
    check("gate_state_armed", 32'(dut_b.state_q), 32'(StArmed));
    check("gate_cnt_zero", frame_cnt_b, 32'd0);
    vs = 1'b0;
    tick();
    check("gate_cnt_restart", frame_cnt_b, 32'd1);
    check("gate_vs_fall", 32'(vs_fall_b), 32'd1);
    check("gate_en_not_yet", 32'(dump_en_b), 32'd0);
    vs = 1'b1;
    tick();
    check("gate_dump_en", 32'(dump_en_b), 32'd1);
    check("gate_dump_start", 32'(dump_start_b), 32'd1);
    repeat (10) tick();
    check("gate_start_pulse", 32'(dump_start_b), 32'd0);

    // Abort: dut_b from DUMPING, dut_a from DONE (USE_LOAD=0 returns to ARMED).
    dwnld_b = 1'b1;
    dwnld_a = 1'b1;
    tick();
    check("abort_stop_b", 32'(dump_stop_b), 32'd1);
    check("abort_en_b", 32'(dump_en_b), 32'd0);
    check("abort_state_b", 32'(dut_b.state_q), 32'(StWaitLoad));
    check("abort_cnt_b", frame_cnt_b, 32'd0);
    check("abort_state_a", 32'(dut_a.state_q), 32'(StArmed));
    check("abort_cnt_a", frame_cnt_a, 32'd0);
    check("abort_stop_a", 32'(dump_stop_a), 32'd0);
    tick();
    check("abort_stop_pulse", 32'(dump_stop_b), 32'd0);
    repeat (3) tick();

    // Fall and download end on the same edge: clear wins.
    vs      = 1'b0;
    dwnld_a = 1'b0;
    dwnld_b = 1'b0;
    tick();
    check("simul_cnt_b", frame_cnt_b, 32'd0);
    check("simul_cnt_a", frame_cnt_a, 32'd0);
    check("simul_vs_fall_b", 32'(vs_fall_b), 32'd1);
    check("simul_state_b", 32'(dut_b.state_q), 32'(StArmed));
    vs = 1'b1;
    repeat (3) tick();

    // Wrap from all-ones.
    force dut_a.frame_cnt = 32'hFFFF_FFFF;
    tick();
    release dut_a.frame_cnt;
    check("wrap_preload", frame_cnt_a, 32'hFFFF_FFFF);
    vs = 1'b0;
    tick();
    check("wrap_cnt", frame_cnt_a, 32'd0);
    check("wrap_vs_fall", 32'(vs_fall_a), 32'd1);
    vs = 1'b1;
    tick();
    check("wrap_vs_fall_pulse", 32'(vs_fall_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
